dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's load/store port. It accepts one word read or write request at a time over a valid/ready handshake and serves it from an internal word-addressed RAM after a fixed, parameterised latency. It returns a response (read data or write acknowledge, plus an error flag) over a second valid/ready handshake. It sits between the core's ALU-generated byte address, store data and write enable, and the core's load-data input.

## Interface
- DATA_WIDTH_P, 32: word width in bits.
- ADDR_WIDTH_P, 32: request byte-address width.
- DEPTH_LOG2_P, 8: log2 of RAM depth in words (256 words).
- LATENCY_P, 2: cycles from request acceptance to response valid; legal range is 1 to 15.

- clk, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- i_req_valid, input, 1: request present.
- o_req_ready, output, 1: responder can accept a request.
- i_req_wr_en, input, 1: 1 = store, 0 = load.
- i_req_addr, input, ADDR_WIDTH_P: byte address.
- i_req_wr_data, input, DATA_WIDTH_P: store data.
- o_rsp_valid, output, 1: response present.
- i_rsp_ready, input, 1: requester accepts the response.
- o_rsp_rd_data, output, DATA_WIDTH_P: load data. Zero for stores and errors.
- o_rsp_err, output, 1: misaligned or out-of-range request.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. o_req_ready = (state == IDLE), registered. o_rsp_valid = (state == RESP), registered.
- **IDLE**: on i_req_valid && o_req_ready, latch wr_en, addr and wr_data, load the latency counter with LATENCY_P-1, and go to WAIT. Without a handshake, stay in IDLE; request inputs are ignored.
- **WAIT**: the counter decrements each cycle. On the edge where the counter is 0:
  - Commit the access and go to RESP.
  - A valid store writes RAM[addr[DEPTH_LOG2_P+1:2]].
  - A valid load captures that word into o_rsp_rd_data.
  - o_rsp_err and o_rsp_rd_data are registered on this same edge.
- **Error conditions**: addr[1:0] != 0, or any of addr[ADDR_WIDTH_P-1:DEPTH_LOG2_P+2] nonzero. On error:
  - No RAM write.
  - o_rsp_rd_data = 0, o_rsp_err = 1.
- **Store response**: o_rsp_rd_data = 0, o_rsp_err = 0.
- **RESP**: hold o_rsp_valid, o_rsp_rd_data and o_rsp_err stable until i_rsp_ready. On the handshake edge, go to IDLE.
- Only one transaction is outstanding at a time. A request cannot be accepted on the same edge a response completes.
- The RAM array is not reset; its contents survive reset.
- The counter width is 4 bits.

## Timing
- **Reset values** (while reset is low): state = IDLE, o_req_ready = 0, o_rsp_valid = 0, o_rsp_rd_data = 0, o_rsp_err = 0, counter = 0.
- **After reset release**: o_req_ready rises on the first rising edge after reset goes high.
- **Acceptance to response**: request accepted at edge N → o_rsp_valid high after edge N+LATENCY_P.
- **Store visibility**: a store is visible to any load accepted after its response.
- **Throughput**: with i_rsp_ready held high, the minimum spacing between accept edges is LATENCY_P+2 cycles. Breakdown:
  - LATENCY_P cycles in WAIT.
  - 1 cycle in RESP.
  - 1 cycle in IDLE with o_req_ready high.
- **Backpressure**: i_rsp_ready low holds RESP indefinitely, with outputs unchanged, and o_req_ready stays 0.
- **Reset mid-operation** (any state): the transaction is aborted and all outputs return to their reset values.
  - If reset asserts before the commit edge, a pending store is not written.
  - A store already committed (state RESP) remains in RAM.

## Test plan
- **Store then load**: store 0xDEADBEEF to addr 0x10, then load addr 0x10 → store response err = 0, rd_data = 0; load response rd_data = 0xDEADBEEF, err = 0.
- **Latency**: with LATENCY_P = 2, accept at edge N → o_rsp_valid rises after edge N+2. With LATENCY_P = 1 → after edge N+1. Check o_req_ready = 0 throughout WAIT and RESP.
- **Error cases**:
  - Load addr 0x13 → err = 1, rd_data = 0.
  - Store 0x12345678 to addr 0x400 (DEPTH_LOG2_P = 8) → err = 1.
  - Subsequent load of word 0 (addr 0x000) returns its prior value unchanged.
- **Backpressure**: hold i_rsp_ready low for 5 cycles → o_rsp_valid, o_rsp_rd_data and o_rsp_err are stable for all 5 cycles. With i_req_valid held high during this time, no second request is accepted. Release i_rsp_ready → IDLE next cycle, then the next request is accepted.
- **Reset mid-operation**:
  - Write 0xAAAA5555 to addr 0x20.
  - Accept a store of 0x11111111 to addr 0x20 (LATENCY_P = 3), then pull reset low one cycle into WAIT.
  - Check all outputs are at their reset values while reset is low.
  - Release reset and load addr 0x20 → 0xAAAA5555.
- **Back-to-back traffic**: issue 16 alternating random stores and loads to addresses 0x000 to 0x3FC with random i_rsp_ready → every load matches a reference memory model, and accepts are never closer than LATENCY_P+2 cycles apart.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder backed by a
// word-addressed RAM. A request is accepted in IDLE and held in WAIT for a
// fixed latency. The access then commits and the registered response is
// presented in RESP until the requester takes it.
module dmem_responder #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 32,
    parameter int DEPTH_LOG2_P = 8,
    parameter int LATENCY_P    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_wr_en,
    input  logic [ADDR_WIDTH_P-1:0] i_req_addr,
    input  logic [DATA_WIDTH_P-1:0] i_req_wr_data,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH_P-1:0] o_rsp_rd_data,
    output logic                    o_rsp_err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2_P;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY_P - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH_P-1:0] addr_q;
    logic [DATA_WIDTH_P-1:0] wr_data_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH_P-1:0] rd_data_q;
    logic                    err_q;

    logic [DATA_WIDTH_P-1:0] mem [DEPTH];

    logic                    addr_err;
    logic [DEPTH_LOG2_P-1:0] word_idx;
    logic                    commit;
    logic                    mem_write;

    // Decode the latched address: misaligned or beyond the RAM is an error,
    // and the access commits on the last WAIT cycle.
    always_comb begin
        addr_err  = (addr_q[1:0] != 2'b00) ||
                    ((addr_q >> (DEPTH_LOG2_P + 2)) != '0);
        word_idx  = addr_q[DEPTH_LOG2_P+1:2];
        commit    = (state_q == WAIT) && (cnt_q == 4'd0);
        mem_write = commit && wr_en_q && !addr_err;
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid && req_ready_q) begin
                        wr_en_q     <= i_req_wr_en;
                        addr_q      <= i_req_addr;
                        wr_data_q   <= i_req_wr_data;
                        cnt_q       <= LAT_INIT;
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (commit) begin
                        err_q       <= addr_err;
                        rd_data_q   <= (!wr_en_q && !addr_err) ? mem[word_idx] : '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM write port; the array is deliberately left out of reset so its
    // contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[word_idx] <= wr_data_q;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rd_data = rd_data_q;
    assign o_rsp_err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (latency 2, 1 and 3) checked every
// cycle against a transaction-timeline model, plus directed literal checks.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rstN;

    logic [2:0]       reqValid;
    logic [2:0]       reqReady;
    logic [2:0]       reqWrEn;
    logic [2:0][31:0] reqAddr;
    logic [2:0][31:0] reqWrData;
    logic [2:0]       rspValid;
    logic [2:0]       rspReady;
    logic [2:0][31:0] rspRdData;
    logic [2:0]       rspErr;

    int testCount = 0;
    int failCount = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        dmem_responder #(
            .DATA_WIDTH_P(32),
            .ADDR_WIDTH_P(32),
            .DEPTH_LOG2_P(8),
            .LATENCY_P   (g == 0 ? 2 : (g == 1 ? 1 : 3))
        ) u (
            .clk          (clk),
            .reset        (rstN),
            .i_req_valid  (reqValid[g]),
            .o_req_ready  (reqReady[g]),
            .i_req_wr_en  (reqWrEn[g]),
            .i_req_addr   (reqAddr[g]),
            .i_req_wr_data(reqWrData[g]),
            .o_rsp_valid  (rspValid[g]),
            .i_rsp_ready  (rspReady[g]),
            .o_rsp_rd_data(rspRdData[g]),
            .o_rsp_err    (rspErr[g])
        );
    end

    function automatic int lat(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model state: each transaction is a timeline (accept cycle, commit at
    // accept+latency, response until taken) against a plain array memory.
    int          cyc = 0;
    int          phase [3];
    bit          readyExp [3];
    bit          mWr [3];
    logic [31:0] mAddr [3];
    logic [31:0] mData [3];
    logic [31:0] mRd [3];
    bit          mErr [3];
    int          accCyc [3];
    int          lastAcc [3] = '{-1, -1, -1};
    logic        prevReady [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] mMem [3][256];

    // Advance the model on each rising edge, then compare all DUT outputs
    // just after the edge.
    always begin
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (!rstN) begin
                phase[k]    = 0;
                readyExp[k] = 1'b0;
                mRd[k]      = 32'h0;
                mErr[k]     = 1'b0;
            end else begin
                case (phase[k])
                    0: begin
                        if (readyExp[k] && reqValid[k]) begin
                            mWr[k]      = reqWrEn[k];
                            mAddr[k]    = reqAddr[k];
                            mData[k]    = reqWrData[k];
                            accCyc[k]   = cyc;
                            phase[k]    = 1;
                            readyExp[k] = 1'b0;
                        end else begin
                            readyExp[k] = 1'b1;
                        end
                    end
                    1: begin
                        if (cyc - accCyc[k] == lat(k)) begin
                            mErr[k] = (mAddr[k] % 4 != 0) || (mAddr[k] >= 32'h400);
                            if (mWr[k] && !mErr[k]) mMem[k][mAddr[k] / 4] = mData[k];
                            mRd[k] = (!mWr[k] && !mErr[k]) ? mMem[k][mAddr[k] / 4] : 32'h0;
                            phase[k] = 2;
                        end
                    end
                    default: begin
                        if (rspReady[k]) begin
                            phase[k]    = 0;
                            readyExp[k] = 1'b1;
                        end
                    end
                endcase
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!rstN) begin
                lastAcc[k]   = -1;
                prevReady[k] = 1'b0;
            end else begin
                if (reqValid[k] && prevReady[k]) begin
                    if (lastAcc[k] >= 0) begin
                        testCount++;
                        if (cyc - lastAcc[k] < lat(k) + 2) begin
                            failCount++;
                            $display("[TB] FAIL accept spacing dut%0d: got %0d cycles, required >= %0d",
                                     k, cyc - lastAcc[k], lat(k) + 2);
                        end
                    end
                    lastAcc[k] = cyc;
                end
                prevReady[k] = reqReady[k];
            end
            checkOutput($sformatf("model req_ready dut%0d cyc%0d", k, cyc), 32'(reqReady[k]), 32'(readyExp[k]));
            checkOutput($sformatf("model rsp_valid dut%0d cyc%0d", k, cyc), 32'(rspValid[k]), 32'(phase[k] == 2));
            if (phase[k] == 2 || !rstN) begin
                checkOutput($sformatf("model rd_data dut%0d cyc%0d", k, cyc), rspRdData[k], mRd[k]);
                checkOutput($sformatf("model err dut%0d cyc%0d", k, cyc), 32'(rspErr[k]), 32'(mErr[k]));
            end
        end
    end

    // Present one request and hold it until accepted; returns on the falling
    // edge right after the accept edge.
    task automatic applyStimulus(int k, bit wr, logic [31:0] addr, logic [31:0] data);
        int n;
        @(negedge clk);
        reqValid[k]  = 1'b1;
        reqWrEn[k]   = wr;
        reqAddr[k]   = addr;
        reqWrData[k] = data;
        n = 0;
        while (reqReady[k] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL accept timeout dut%0d: got no ready, required ready within 40 cycles", k);
        end
        @(posedge clk);
        @(negedge clk);
        reqValid[k] = 1'b0;
    endtask

    // Wait for the response, check latency and payload, then complete it.
    task automatic waitResponse(int k, logic [31:0] expRd, bit expErr, bit randReady, string name);
        int n;
        n = 0;
        while (rspValid[k] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " latency"}, n, lat(k));
        checkOutput({name, " rd_data"}, rspRdData[k], expRd);
        checkOutput({name, " err"}, 32'(rspErr[k]), 32'(expErr));
        if (randReady) begin
            for (int i = 0; i < 20; i++) begin
                rspReady[k] = (i == 19) ? 1'b1 : 1'($urandom_range(0, 1));
                if (rspReady[k]) break;
                @(negedge clk);
            end
        end else begin
            rspReady[k] = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic doTxn(int k, bit wr, logic [31:0] addr, logic [31:0] data,
                         logic [31:0] expRd, bit expErr, string name);
        applyStimulus(k, wr, addr, data);
        waitResponse(k, expRd, expErr, 1'b0, name);
    endtask

    // Directed scenarios followed by randomised store/load traffic.
    initial begin : mainSeq
        int          n;
        int          a;
        logic [31:0] d;
        logic [31:0] sbMem [int];
        int          addrList [$];

        rstN      = 1'b0;
        reqValid  = '0;
        reqWrEn   = '0;
        reqAddr   = '0;
        reqWrData = '0;
        rspReady  = '1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset req_ready dut%0d", k), 32'(reqReady[k]), 32'h0);
            checkOutput($sformatf("reset rsp_valid dut%0d", k), 32'(rspValid[k]), 32'h0);
            checkOutput($sformatf("reset rd_data dut%0d", k), rspRdData[k], 32'h0);
            checkOutput($sformatf("reset err dut%0d", k), 32'(rspErr[k]), 32'h0);
        end
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready after reset release", 32'(reqReady), 32'h7);

        doTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "store 0x10");
        doTxn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "load 0x10");
        doTxn(0, 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, "store word0");
        doTxn(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "load misaligned 0x13");
        doTxn(0, 1'b1, 32'h400, 32'h12345678, 32'h0, 1'b1, "store out of range 0x400");
        doTxn(0, 1'b1, 32'h80000004, 32'h55555555, 32'h0, 1'b1, "store high address");
        doTxn(0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "load word0 unchanged");

        doTxn(1, 1'b1, 32'h44, 32'h01234567, 32'h0, 1'b0, "lat1 store");
        doTxn(1, 1'b0, 32'h44, 32'h0, 32'h01234567, 1'b0, "lat1 load");

        rspReady[0] = 1'b0;
        applyStimulus(0, 1'b0, 32'h10, 32'h0);
        n = 0;
        while (rspValid[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("backpressure latency", n, 2);
        reqValid[0] = 1'b1;
        reqWrEn[0]  = 1'b0;
        reqAddr[0]  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("backpressure rsp_valid held", 32'(rspValid[0]), 32'h1);
            checkOutput("backpressure rd_data held", rspRdData[0], 32'hDEADBEEF);
            checkOutput("backpressure err held", 32'(rspErr[0]), 32'h0);
            checkOutput("backpressure req_ready low", 32'(reqReady[0]), 32'h0);
        end
        rspReady[0] = 1'b1;
        @(negedge clk);
        checkOutput("release req_ready", 32'(reqReady[0]), 32'h1);
        checkOutput("release rsp_valid", 32'(rspValid[0]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        waitResponse(0, 32'hCAFEF00D, 1'b0, 1'b0, "queued load after backpressure");

        doTxn(2, 1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, "lat3 store");
        applyStimulus(2, 1'b1, 32'h20, 32'h11111111);
        rstN = 1'b0;
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("mid reset req_ready dut%0d", k), 32'(reqReady[k]), 32'h0);
                checkOutput($sformatf("mid reset rsp_valid dut%0d", k), 32'(rspValid[k]), 32'h0);
                checkOutput($sformatf("mid reset rd_data dut%0d", k), rspRdData[k], 32'h0);
                checkOutput($sformatf("mid reset err dut%0d", k), 32'(rspErr[k]), 32'h0);
            end
        end
        rstN = 1'b1;
        doTxn(2, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0, "lat3 load after aborted store");

        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                a = int'($urandom_range(0, 255)) * 4;
                d = $urandom;
                applyStimulus(0, 1'b1, a, d);
                waitResponse(0, 32'h0, 1'b0, 1'b1, "random store");
                sbMem[a] = d;
                addrList.push_back(a);
            end else begin
                a = addrList[$urandom_range(0, addrList.size() - 1)];
                applyStimulus(0, 1'b0, a, 32'h0);
                waitResponse(0, sbMem[a], 1'b0, 1'b1, "random load");
            end
        end
        rspReady[0] = 1'b1;

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
